instruction_prefetch: RTL and testbench
=======================================

// Module: instruction_prefetch
// PURPOSE
//  Wishbone classic master that fetches sequential 32-bit instruction words for the CPU core from the
//  block-RAM memory slave and buffers them in a small FIFO. Sits directly upstream of the memory on
//  the instruction bus. Absorbs the slave's one-ack-per-two-cycles rate, retries and bus errors.
//  Redirects (branch/jump/trap) flush the buffer.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset (bits[1:0] must be 0)
//  DEPTH     2              FIFO entries; power of two, >=2
// PORTS
//  clk_i          in   1   clock; all state on rising edge
//  rst_i          in   1   synchronous, active-high reset
//  cyc_o          out  1   wishbone cycle
//  stb_o          out  1   wishbone strobe
//  we_o           out  1   tied 0 (read-only master)
//  sel_o          out  4   tied 4'hF
//  adr_o          out  32  byte address of word being fetched; bits[1:0] always 0
//  dat_i          in   32  read data; already big-endian word order, used unmodified
//  ack_i          in   1   slave ack
//  err_i          in   1   slave error
//  rty_i          in   1   slave retry
//  redirect_i     in   1   one-cycle pulse: discard buffer, restart at redirect_pc_i
//  redirect_pc_i  in   32  new fetch address; bits[1:0] ignored (forced 0)
//  valid_o        out  1   instr_o/pc_o/fault_o hold a buffered entry
//  ready_i        in   1   consumer accepts entry (pop when valid_o & ready_i)
//  instr_o        out  32  instruction word (FIFO head)
//  pc_o           out  32  byte address of instr_o
//  fault_o        out  1   head entry is a bus error; instr_o is 0
// BEHAVIOUR
//  Reset: cyc_o=stb_o=0, valid_o=0, fault_o=0, instr_o=0, pc_o=0, FIFO empty, fetch pc=RESET_PC,
//   halted=0, state IDLE. cyc_o/stb_o first rise in the cycle after rst_i deasserts.
//  Reset mid-transaction drops stb_o/cyc_o immediately; a late ack_i is ignored.
//  States: IDLE (no request), REQ (cyc_o=stb_o=1, adr_o=fetch pc held stable), DRAIN (request
//   outstanding but redirected; response discarded).
//  IDLE->REQ when !halted & (count + 0) < DEPTH. At most one outstanding request.
//  REQ on ack_i: push {dat_i, adr_o, fault=0}, pc+=4, ->IDLE. Strobe drops for >=1 cycle between
//   requests. Sustained rate is 1 word / 2 cycles against the memory slave.
//  REQ on err_i: push {0, adr_o, fault=1}, set halted, ->IDLE. No further fetch until redirect_i.
//  REQ on rty_i: no push, pc unchanged, ->IDLE (same address reissued next eligible cycle).
//  Priority when several responses are asserted together: err_i > ack_i > rty_i.
//  FIFO full: no new request issued. Because count+outstanding never exceeds DEPTH, a push never
//   meets a full FIFO.
//  redirect_i (any state): FIFO cleared (valid_o=0 next cycle), pc<=redirect_pc_i&~3, halted<=0.
//   - In REQ without a response this cycle: ->DRAIN, keep cyc_o/stb_o until ack/err/rty, discard
//     the response, ->IDLE.
//   - With a response in the same cycle: response discarded, ->IDLE.
//   - A pop in the same cycle as redirect_i is void; the flush wins.
//  Simultaneous push and pop: count unchanged, both take effect.
//  pc wraps 32'hFFFF_FFFC+4 -> 32'h0000_0000 silently.
//  Outputs come from registers or the FIFO head; no combinational path from ready_i or ack_i to
//   any output.
// STRUCTURE
//  State encodings (IDLE/REQ/DRAIN) and the entry layout {fault,pc[31:0],instr[31:0]} = 65 bits
//   live as localparams in shared header crush_prefetch_defs.vh.
//  One sub-module: sync_fifo (WIDTH=65, DEPTH), synchronous clear, count output; reusable
//   elsewhere in the SoC.
// TESTING
//  1 Reset RESET_PC=0, memory words 0..3 preloaded, ready_i=1 -> adr_o 0,4,8,C in order; instr_o
//    matches memory; pc_o 0,4,8,C; strobe gaps of >=1 cycle.
//  2 ready_i=0 with DEPTH=2 -> exactly 2 acks, then cyc_o=0. Raise ready_i -> fetching resumes at 8.
//  3 redirect_i to 32'h103 while REQ pending at adr 8 -> that ack discarded; next adr_o=32'h100;
//    first valid pc_o=32'h100.
//  4 err_i on adr 4 -> entry pc_o=4, fault_o=1, instr_o=0; no cyc_o until redirect_i to 0, then
//    fetch restarts at 0.
//  5 rty_i twice on adr 0, then ack -> adr_o stays 0 across all 3 strobes; single entry pushed.
//  6 redirect_pc_i=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000; rst_i asserted mid-REQ ->
//    stb_o=0 next cycle, valid_o=0.

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// Shared types for the instruction prefetcher: fetch FSM states, the
// buffered entry layout and a small address helper.
package instruction_prefetch_pkg;

    // Fetch FSM: IDLE (no request), REQ (request on the bus),
    // DRAIN (request outstanding after a redirect; its response is dropped).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // One buffered entry: {fault, pc, instr}.
    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_prefetch_sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear and an occupancy count.
// DEPTH must be a power of two (pointers wrap naturally). Pushes into a full
// FIFO are refused unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s;
    logic             empty_s;
    logic             push_en_s;
    logic             pop_en_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == CNT_W'(0));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Qualify push/pop against occupancy and compute next pointers/count.
    always_comb begin
        pop_en_s  = pop_i & ~empty_s;
        push_en_s = push_i & (~full_s | pop_en_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clr_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_en_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_en_s) - CNT_W'(pop_en_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (push_en_s && !clr_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Wishbone classic read master fetching sequential instruction words into a
// small FIFO. One request outstanding at most; the strobe drops for a cycle
// after every response. Redirects flush the buffer and restart fetching,
// bus errors are delivered as a faulting entry and stop fetching until the
// next redirect.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      adr_q, adr_d;
    logic             halted_q, halted_d;

    logic [CNT_W-1:0] fifo_count_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_entry_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;
    logic             room_s;
    logic             any_resp_s;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (redirect_i),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_entry_s),
        .count_o     (fifo_count_s)
    );

    assign valid_s    = (fifo_count_s != CNT_W'(0));
    // In IDLE nothing is outstanding, so occupancy alone bounds the total.
    assign room_s     = (fifo_count_s < CNT_W'(DEPTH));
    assign any_resp_s = ack_i | err_i | rty_i;
    // A pop coinciding with a redirect is void: the flush wins.
    assign pop_s      = valid_s & ready_i & ~redirect_i;

    // Bus outputs are decoded from registered state only.
    assign cyc_o   = (state_q != ST_IDLE);
    assign stb_o   = (state_q != ST_IDLE);
    assign we_o    = 1'b0;
    assign sel_o   = 4'hF;
    assign adr_o   = adr_q;

    // Consumer outputs come from the FIFO head, zeroed while empty.
    assign valid_o = valid_s;
    assign instr_o = valid_s ? head_entry_s.instr : 32'h0000_0000;
    assign pc_o    = valid_s ? head_entry_s.pc    : 32'h0000_0000;
    assign fault_o = valid_s ? head_entry_s.fault : 1'b0;

    // Next-state logic: request issue, response handling and redirect.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        adr_d        = adr_q;
        halted_d     = halted_q;
        push_s       = 1'b0;
        push_entry_s = '0;

        case (state_q)
            ST_IDLE: begin
                // A redirect cycle must not launch a fetch from the old pc.
                if (redirect_i) begin
                    state_d = ST_IDLE;
                end else if (!halted_q && room_s) begin
                    state_d = ST_REQ;
                    adr_d   = pc_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    if (any_resp_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (err_i) begin
                    push_s             = 1'b1;
                    push_entry_s.fault = 1'b1;
                    push_entry_s.pc    = adr_q;
                    push_entry_s.instr = 32'h0000_0000;
                    halted_d           = 1'b1;
                    state_d            = ST_IDLE;
                end else if (ack_i) begin
                    push_s             = 1'b1;
                    push_entry_s.fault = 1'b0;
                    push_entry_s.pc    = adr_q;
                    push_entry_s.instr = dat_i;
                    pc_d               = pc_q + 32'd4;
                    state_d            = ST_IDLE;
                end else if (rty_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (any_resp_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_i) begin
            pc_d     = word_align(redirect_pc_i);
            halted_d = 1'b0;
        end else begin
            pc_d     = pc_d;
            halted_d = halted_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= word_align(RESET_PC);
            adr_q    <= 32'h0000_0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            adr_q    <= adr_d;
            halted_q <= halted_d;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomized bench for instruction_prefetch. A behavioural memory slave with
// random wait/retry responses feeds the DUT; the consumer side is checked
// against the expected sequential instruction stream implied by reset and
// redirect history. A fixed address region always answers with a bus error.
module tb_instruction_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_i;
    logic        ack_i, err_i, rty_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o, ready_i;
    logic [31:0] instr_o, pc_o;
    logic        fault_o;

    always #5 clk_i = ~clk_i;

    instruction_prefetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
        .rty_i(rty_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
        .fault_o(fault_o)
    );

    int checks   = 0;
    int failures = 0;

    // Expected consumer stream and slave-side bookkeeping.
    logic [31:0] exp_pc;
    bit          m_halted;
    bit          slave_halt;
    bit          draining;
    bit          prev_resp;
    bit          prev_stb;
    logic [31:0] prev_adr;
    int          pops;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        return (a[9:2] == 8'h0B);
    endfunction

    task automatic model_reset();
        exp_pc     = RESET_PC;
        m_halted   = 1'b0;
        slave_halt = 1'b0;
        draining   = 1'b0;
        prev_resp  = 1'b0;
        prev_stb   = 1'b0;
        prev_adr   = 32'h0;
    endtask

    // One clock: check bus protocol, drive consumer/redirect/slave inputs,
    // and score any entry the consumer accepts at the coming edge.
    task automatic step(input bit force_redir, input logic [31:0] tgt,
                        input bit rand_redir, input int ready_pct);
        bit          redir;
        bit          resp;
        logic [31:0] target;
        int          r;
        @(negedge clk_i);
        if (stb_o) begin
            check_eq("adr_align", {30'd0, adr_o[1:0]}, 32'd0);
            check_eq("sel", {28'd0, sel_o}, 32'hF);
            check_eq("we", {31'd0, we_o}, 32'd0);
        end
        if (prev_resp) begin
            check_eq("stb_gap", {31'd0, stb_o}, 32'd0);
        end else if (prev_stb && stb_o) begin
            check_eq("adr_hold", adr_o, prev_adr);
        end
        if (slave_halt) check_eq("halted_idle", {31'd0, cyc_o}, 32'd0);

        redir  = force_redir | (rand_redir && ($urandom_range(0, 29) == 0));
        target = force_redir ? tgt :
                 (($urandom_range(0, 3) == 0) ? 32'h0000_0103 : 32'($urandom_range(0, 511)));
        redirect_i    = redir;
        redirect_pc_i = target;
        ready_i       = ($urandom_range(0, 99) < ready_pct);

        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = $urandom;
        if (stb_o) begin
            dat_i = mem_word(adr_o);
            r = $urandom_range(0, 7);
            if (is_bad(adr_o)) begin
                if (r >= 3) begin err_i = 1'b1; ack_i = (r == 7); end
            end else if (r == 2) begin
                rty_i = 1'b1;
            end else if (r == 7) begin
                ack_i = 1'b1; rty_i = 1'b1;
            end else if (r >= 3) begin
                ack_i = 1'b1;
            end
        end
        resp = ack_i | err_i | rty_i;

        if (valid_o && ready_i && !redir) begin
            check_eq("entry_after_fault", {31'd0, valid_o}, {31'd0, !m_halted});
            check_eq("pop_pc", pc_o, exp_pc);
            check_eq("pop_instr", instr_o, is_bad(exp_pc) ? 32'h0 : mem_word(exp_pc));
            check_eq("pop_fault", {31'd0, fault_o}, {31'd0, is_bad(exp_pc)});
            if (is_bad(exp_pc)) m_halted = 1'b1;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir) begin
            exp_pc   = {target[31:2], 2'b00};
            m_halted = 1'b0;
        end

        if (redir) slave_halt = 1'b0;
        else if (err_i && !draining) slave_halt = 1'b1;
        if (resp) draining = 1'b0;
        else if (redir && stb_o) draining = 1'b1;
        prev_resp = resp;
        prev_stb  = stb_o;
        prev_adr  = adr_o;
    endtask

    initial begin
        int waited;
        int pops_before;
        rst_i = 1'b1; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 32'h0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0; ready_i = 1'b0;
        pops = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check_eq("rst_cyc", {31'd0, cyc_o}, 32'd0);
        check_eq("rst_stb", {31'd0, stb_o}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_fault", {31'd0, fault_o}, 32'd0);
        check_eq("rst_instr", instr_o, 32'h0);
        check_eq("rst_pc", pc_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq("first_cyc", {31'd0, cyc_o}, 32'd1);
        check_eq("first_adr", adr_o, RESET_PC);

        // Sequential fetch with an always-ready consumer.
        repeat (20) step(1'b0, 32'h0, 1'b0, 100);
        check_eq("seq_progress", {31'd0, (pops >= 3)}, 32'd1);

        // Consumer stalls: FIFO fills, bus goes quiet.
        repeat (40) step(1'b0, 32'h0, 1'b0, 0);
        check_eq("full_cyc", {31'd0, cyc_o}, 32'd0);
        check_eq("full_valid", {31'd0, valid_o}, 32'd1);

        // Redirect to an unaligned target; stream restarts at 0x100.
        step(1'b1, 32'h0000_0103, 1'b0, 100);
        repeat (30) step(1'b0, 32'h0, 1'b0, 80);

        // Address wrap at the top of the address space.
        pops_before = pops;
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 100);
        repeat (20) step(1'b0, 32'h0, 1'b0, 100);
        check_eq("wrap_pops", {31'd0, (pops - pops_before >= 2)}, 32'd1);

        // Long randomized run with random redirects and backpressure.
        repeat (3000) step(1'b0, 32'h0, 1'b1, 70);

        // Reset while a request is on the bus, with a late ack.
        waited = 0;
        while (!stb_o && waited < 50) begin
            step(1'b1, 32'h0000_0040, 1'b0, 100);
            waited++;
        end
        check_eq("req_before_rst", {31'd0, stb_o}, 32'd1);
        rst_i = 1'b1; ack_i = 1'b1; dat_i = 32'hDEAD_BEEF;
        redirect_i = 1'b0;
        @(negedge clk_i);
        check_eq("midrst_stb", {31'd0, stb_o}, 32'd0);
        check_eq("midrst_cyc", {31'd0, cyc_o}, 32'd0);
        check_eq("midrst_valid", {31'd0, valid_o}, 32'd0);
        ack_i = 1'b0;
        rst_i = 1'b0;
        model_reset();
        repeat (300) step(1'b0, 32'h0, 1'b1, 70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
